// File: rtl/eth_clk_pkg.sv
// Shared definitions for the MAC forwarded-clock path: divider FSM encoding and
// the standard half-period divisors for a 125 MHz source clock.
package eth_clk_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } clk_state_e;

  localparam logic [1:0] ST_IDLE     = IDLE;
  localparam logic [1:0] ST_RUN      = RUN;
  localparam logic [1:0] ST_STOPPING = STOPPING;

  // Half-periods (in clk_i half-cycles) for 1000 / 100 / 10 Mb/s line rates
  localparam int HALF_GIG  = 1;
  localparam int HALF_FAST = 5;
  localparam int HALF_TEN  = 50;

endpackage

// File: rtl/oddr_clock_phase_gen.sv
// Half-slot phase arithmetic for the DDR clock generator: turns the current even
// phase and half-period H into a (rise, fall) level pair, next phase and wrap flag.
module oddr_clock_phase_gen #(
  parameter int div_width_p = 8
) (
  input  logic [div_width_p:0]   ph,
  input  logic [div_width_p-1:0] half_period,
  output logic [1:0]             slot_pair,
  output logic [div_width_p:0]   ph_next,
  output logic                   wrap
);

  localparam int AW = div_width_p + 2;

  logic [AW-1:0] ph_ext;
  logic [AW-1:0] two_h;
  logic [AW-1:0] ph_plus2;

  assign ph_ext   = {1'b0, ph};
  assign two_h    = {1'b0, half_period, 1'b0};
  assign ph_plus2 = ph_ext + AW'(2);
  assign wrap     = (ph_plus2 >= two_h);

  // ph is even and never exceeds 2H-2, so a wrap always lands exactly on zero
  assign ph_next = wrap ? '0 : ph_plus2[div_width_p:0];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      logic [AW-1:0] slot_idx;
      assign slot_idx      = ph_ext + AW'(gi);
      assign slot_pair[gi] = (slot_idx < {2'b00, half_period});
    end
  endgenerate

endmodule

// File: rtl/oddr_clock_divider_ddr.sv
// Programmable 50%-duty forwarded-clock generator emitting DDR slot pairs for an ODDR.
// Divisor changes and enable/disable take effect only at output period boundaries.
module oddr_clock_divider_ddr
  import eth_clk_pkg::*;
#(
  parameter int div_width_p = 8,
  parameter int init_div_p  = 1
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   en_i,
  input  logic                   div_v_i,
  input  logic [div_width_p-1:0] div_i,
  output logic                   div_ready_o,
  output logic [1:0]             ddr_o,
  output logic                   period_start_o,
  output logic                   running_o
);

  localparam logic [div_width_p-1:0] INIT_H =
    (init_div_p < 1) ? div_width_p'(1) : div_width_p'(init_div_p);

  logic [1:0]             state_reg, state_next;
  logic [div_width_p:0]   ph_reg, ph_next;
  logic [div_width_p-1:0] h_active_reg, h_active_next;
  logic [div_width_p-1:0] h_pend_reg, h_pend_next;
  logic                   pend_valid_reg, pend_valid_next;
  logic [1:0]             ddr_reg, ddr_next;
  logic                   start_reg, start_next;
  logic                   running_reg, running_next;

  logic [1:0]             slot_pair;
  logic [div_width_p:0]   ph_adv;
  logic                   wrap;
  logic                   accept;
  logic [div_width_p-1:0] div_clamped;

  oddr_clock_phase_gen #(
    .div_width_p (div_width_p)
  ) u_phase_gen (
    .ph          (ph_reg),
    .half_period (h_active_reg),
    .slot_pair   (slot_pair),
    .ph_next     (ph_adv),
    .wrap        (wrap)
  );

  assign accept      = div_v_i & ~pend_valid_reg;
  assign div_clamped = (div_i == '0) ? div_width_p'(1) : div_i;

  always_comb begin
    state_next      = state_reg;
    ph_next         = ph_reg;
    h_active_next   = h_active_reg;
    h_pend_next     = h_pend_reg;
    pend_valid_next = pend_valid_reg;
    ddr_next        = 2'b00;
    start_next      = 1'b0;
    running_next    = 1'b0;

    if (state_reg == ST_IDLE) begin
      ph_next = '0;
      // Output is parked, so a new divisor can go straight into use
      if (accept) begin
        h_active_next = div_clamped;
      end else if (pend_valid_reg) begin
        h_active_next   = h_pend_reg;
        pend_valid_next = 1'b0;
      end
      if (en_i) begin
        state_next = ST_RUN;
      end
    end else begin
      ddr_next     = slot_pair;
      start_next   = (ph_reg == '0);
      running_next = 1'b1;
      ph_next      = ph_adv;
      if (accept) begin
        h_pend_next     = div_clamped;
        pend_valid_next = 1'b1;
      end
      if (wrap) begin
        if (pend_valid_reg) begin
          h_active_next   = h_pend_reg;
          pend_valid_next = 1'b0;
        end
        state_next = en_i ? ST_RUN : ST_IDLE;
      end else begin
        state_next = en_i ? ST_RUN : ST_STOPPING;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg      <= ST_IDLE;
      ph_reg         <= '0;
      h_active_reg   <= INIT_H;
      h_pend_reg     <= '0;
      pend_valid_reg <= 1'b0;
      ddr_reg        <= 2'b00;
      start_reg      <= 1'b0;
      running_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ph_reg         <= ph_next;
      h_active_reg   <= h_active_next;
      h_pend_reg     <= h_pend_next;
      pend_valid_reg <= pend_valid_next;
      ddr_reg        <= ddr_next;
      start_reg      <= start_next;
      running_reg    <= running_next;
    end
  end

  assign ddr_o          = ddr_reg;
  assign period_start_o = start_reg;
  assign running_o      = running_reg;
  assign div_ready_o    = ~pend_valid_reg;

endmodule
